read_test_engine: RTL

//  Parametrised pipe-out throughput test core: pattern generator -> internal FIFO -> okPipeOut data path,

---
 rtl/read_test_engine.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/read_test_engine.sv
// read_test_engine
// Pipe-out throughput test core: a pattern generator fills an internal FIFO that the host drains
// through an okPipeOut endpoint, while a 64-bit okClk cycle timer and word counters report how
// long the transfer took.
//
// Ports
//   okClk          sole clock, rising edge
//   reset          synchronous, active-high; clears state, counters, flags and the FIFO
//   start          1-cycle trigger, begins a run (accepted only in IDLE or DONE)
//   stop           1-cycle trigger, aborts a run (honoured only in RUN or DRAIN)
//   pattern_mode   0 counter, 1 Galois LFSR, 2 walking-one, 3 constant
//   pattern_seed   first generated word, sampled on an accepted start
//   word_target    words per run, 0 = unlimited; sampled on an accepted start
//   pipe_read      okPipeOut ep_read
//   pipe_data      okPipeOut ep_datain, valid the cycle after pipe_read, held until next pop
//   clk_counts     okClk cycles spent in RUN or DRAIN
//   words_read     words popped by the pipe this run
//   fifo_level     current FIFO occupancy
//   busy           state is RUN or DRAIN
//   done           state is DONE
//   underflow_err  sticky, set by pipe_read on an empty FIFO
module read_test_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                        okClk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  pattern_mode,
  input  logic [DATA_WIDTH-1:0]       pattern_seed,
  input  logic [31:0]                 word_target,
  input  logic                        pipe_read,
  output logic [DATA_WIDTH-1:0]       pipe_data,
  output logic [63:0]                 clk_counts,
  output logic [31:0]                 words_read,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        done,
  output logic                        underflow_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  // Generator stalls at or above this occupancy, so the FIFO can never be pushed while full.
  localparam logic [LvlW-1:0] StallLvl = LvlW'(FIFO_DEPTH - AF_MARGIN);

  localparam logic [63:0]           Taps64 = 64'hD800_0000_0000_0000;
  localparam logic [DATA_WIDTH-1:0] Taps   = (DATA_WIDTH == 64) ? Taps64[DATA_WIDTH-1:0]
                                                                : DATA_WIDTH'(32'h8020_0003);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [1:0] ModeCount = 2'd0;
  localparam logic [1:0] ModeLfsr  = 2'd1;
  localparam logic [1:0] ModeWalk  = 2'd2;
  localparam logic [1:0] ModeConst = 2'd3;

  // LFSR and walking-one would lock up on an all-zero value.
  function automatic logic [DATA_WIDTH-1:0] fix_seed(input logic [1:0]            mode,
                                                     input logic [DATA_WIDTH-1:0] seed);
    logic [DATA_WIDTH-1:0] res;
    res = seed;
    if ((mode == ModeLfsr || mode == ModeWalk) && seed == '0) begin
      res = DATA_WIDTH'(1);
    end
    return res;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0]            mode,
                                                      input logic [DATA_WIDTH-1:0] cur);
    logic [DATA_WIDTH-1:0] res;
    res = cur;
    case (mode)
      ModeCount: res = cur + DATA_WIDTH'(1);
      ModeLfsr:  res = cur[0] ? ((cur >> 1) ^ Taps) : (cur >> 1);
      ModeWalk:  res = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
      ModeConst: res = cur;
      default:   res = cur;
    endcase
    return res;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] gen_val_q;
  logic [31:0]           gen_count_q;
  logic [31:0]           target_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q;
  logic [DATA_WIDTH-1:0] pipe_data_q;
  logic [63:0]           clk_counts_q;
  logic [31:0]           words_read_q;
  logic                  underflow_q;

  logic start_ok;
  logic in_run;
  logic in_busy;
  logic target_met;
  logic push;
  logic pop;

  always_comb begin
    start_ok   = start && (state_q == StIdle || state_q == StDone);
    in_run     = (state_q == StRun);
    in_busy    = (state_q == StRun) || (state_q == StDrain);
    target_met = (target_q != 32'd0) && (gen_count_q == target_q);
    // No word is generated on the cycle stop is seen.
    push       = in_run && !stop && (level_q < StallLvl) && !target_met;
    // A read landing on the same cycle as an accepted start is swallowed by the flush.
    pop        = pipe_read && (level_q != '0) && !start_ok;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (stop)            state_d = StDone;
        else if (target_met) state_d = StDrain;
      end
      StDrain: begin
        if (stop)                         state_d = StDone;
        else if (words_read_q == target_q) state_d = StDone;
      end
      StDone: if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q      <= StIdle;
      gen_val_q    <= '0;
      gen_count_q  <= '0;
      target_q     <= '0;
      mode_q       <= ModeCount;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pipe_data_q  <= '0;
      clk_counts_q <= '0;
      words_read_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        gen_val_q    <= fix_seed(pattern_mode, pattern_seed);
        gen_count_q  <= '0;
        target_q     <= word_target;
        mode_q       <= pattern_mode;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        level_q      <= '0;
        clk_counts_q <= '0;
        words_read_q <= '0;
        underflow_q  <= 1'b0;
      end else begin
        if (in_busy) begin
          clk_counts_q <= clk_counts_q + 64'd1;
        end
        if (push) begin
          gen_val_q   <= next_word(mode_q, gen_val_q);
          gen_count_q <= gen_count_q + 32'd1;
          wr_ptr_q    <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          pipe_data_q  <= mem[rd_ptr_q];
          rd_ptr_q     <= rd_ptr_q + PtrW'(1);
          words_read_q <= words_read_q + 32'd1;
        end
        if (pipe_read && level_q == '0) begin
          underflow_q <= 1'b1;
        end
        case ({push, pop})
          2'b10:   level_q <= level_q + LvlW'(1);
          2'b01:   level_q <= level_q - LvlW'(1);
          default: level_q <= level_q;
        endcase
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge okClk) begin
    if (push) begin
      mem[wr_ptr_q] <= gen_val_q;
    end
  end

  assign pipe_data     = pipe_data_q;
  assign clk_counts    = clk_counts_q;
  assign words_read    = words_read_q;
  assign fifo_level    = level_q;
  assign busy          = in_busy;
  assign done          = (state_q == StDone);
  assign underflow_err = underflow_q;

endmodule
